// File: rtl/imm_op_sequencer_if.sv
// Control-strobe bundle between the immediate-class sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath.
interface imm_op_sequencer_if;
    logic        run;
    logic        step_mode;
    logic        mem_ready;
    logic [31:0] ir;

    logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin, MDRout, IRin;
    logic Gra, Grb, Rin, Rout, BAout, Yin, Csignout;
    logic ADD, AND, OR;
    logic done, illegal, bus_error;

    modport master (
        input  run, step_mode, mem_ready, ir,
        output PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin, MDRout, IRin,
        output Gra, Grb, Rin, Rout, BAout, Yin, Csignout,
        output ADD, AND, OR,
        output done, illegal, bus_error
    );

    modport slave (
        output run, step_mode, mem_ready, ir,
        input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin, MDRout, IRin,
        input  Gra, Grb, Rin, Rout, BAout, Yin, Csignout,
        input  ADD, AND, OR,
        input  done, illegal, bus_error
    );
endinterface

// File: rtl/imm_op_sequencer.sv
// Fetch/execute control sequencer for addi/andi/ori. Strobes are decoded from the
// registered state; T1 and T3 also look at mem_ready and ir, which are only valid there.
module imm_op_sequencer #(
    parameter int               OPC_W    = 5,
    parameter logic [OPC_W-1:0] ADDI_OPC = 5'b01100,
    parameter logic [OPC_W-1:0] ANDI_OPC = 5'b01101,
    parameter logic [OPC_W-1:0] ORI_OPC  = 5'b01110,
    parameter int               TIMEOUT  = 8
) (
    input  logic                clock,
    input  logic                clear,
    imm_op_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_AND, OP_OR} alu_op_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    alu_op_t          op_reg, op_next;
    alu_op_t          dec_op;

    logic [OPC_W-1:0] opcode;
    logic [3:0]       rb_field;
    logic             ir_unused;

    assign opcode    = bus.ir[31:32-OPC_W];
    assign rb_field  = bus.ir[22:19];
    assign ir_unused = ^bus.ir;

    always_comb begin
        dec_op = OP_NONE;
        if (opcode == ADDI_OPC)      dec_op = OP_ADD;
        else if (opcode == ANDI_OPC) dec_op = OP_AND;
        else if (opcode == ORI_OPC)  dec_op = OP_OR;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            op_reg       <= OP_NONE;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            op_reg       <= op_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        op_next       = op_reg;
        bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPC = 1'b0; bus.Zlowin = 1'b0;
        bus.Zlowout = 1'b0; bus.PCin = 1'b0; bus.Read = 1'b0; bus.MD_read = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
        bus.BAout = 1'b0; bus.Yin = 1'b0; bus.Csignout = 1'b0;
        bus.ADD = 1'b0; bus.AND = 1'b0; bus.OR = 1'b0;
        bus.done = 1'b0; bus.illegal = 1'b0; bus.bus_error = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.run) state_next = S_T0;
            end
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_T1;
            end
            S_T1: begin
                bus.Read = 1'b1; bus.MD_read = 1'b1; bus.MDRin = 1'b1;
                // PC write-back only on the first wait cycle so the PC moves exactly once
                if (wait_cnt_reg == '0) begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_next = S_T2;
                end else if (wait_cnt_reg == LAST_WAIT) begin
                    bus.bus_error = 1'b1;
                    state_next    = S_IDLE;
                end else if (wait_cnt_reg != CNT_MAX) begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (dec_op == OP_NONE) begin
                    bus.illegal = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    bus.Grb = 1'b1; bus.Yin = 1'b1;
                    bus.BAout = (rb_field == 4'd0);
                    bus.Rout  = (rb_field != 4'd0);
                    op_next    = dec_op;
                    state_next = S_T4;
                end
            end
            S_T4: begin
                bus.Csignout = 1'b1; bus.Zlowin = 1'b1;
                bus.ADD = (op_reg == OP_ADD);
                bus.AND = (op_reg == OP_AND);
                bus.OR  = (op_reg == OP_OR);
                state_next = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; bus.done = 1'b1;
                state_next = (bus.run && !bus.step_mode) ? S_T0 : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_imm_op_sequencer.sv
// Bench for imm_op_sequencer: two instances (TIMEOUT 8 and 4) share stimulus and are
// compared every cycle against an instruction-timeline model, plus directed literal checks.
module tb_imm_op_sequencer;
    localparam int B_PCOUT = 23, B_MARIN = 22, B_INCPC = 21, B_ZLOWIN = 20, B_ZLOWOUT = 19;
    localparam int B_PCIN = 18, B_READ = 17, B_MDREAD = 16, B_MDRIN = 15, B_MDROUT = 14;
    localparam int B_IRIN = 13, B_GRA = 12, B_GRB = 11, B_RIN = 10, B_ROUT = 9, B_BAOUT = 8;
    localparam int B_YIN = 7, B_CSIGN = 6, B_ADD = 5, B_AND = 4, B_OR = 3;
    localparam int B_DONE = 2, B_ILL = 1, B_BERR = 0;

    localparam logic [23:0] ONE      = 24'd1;
    localparam logic [23:0] V_T0     = (ONE << B_PCOUT) | (ONE << B_MARIN) | (ONE << B_INCPC) | (ONE << B_ZLOWIN);
    localparam logic [23:0] V_T1F    = (ONE << B_ZLOWOUT) | (ONE << B_PCIN) | (ONE << B_READ) | (ONE << B_MDREAD) | (ONE << B_MDRIN);
    localparam logic [23:0] V_T2     = (ONE << B_MDROUT) | (ONE << B_IRIN);
    localparam logic [23:0] V_T3B    = (ONE << B_GRB) | (ONE << B_BAOUT) | (ONE << B_YIN);
    localparam logic [23:0] V_T3R    = (ONE << B_GRB) | (ONE << B_ROUT) | (ONE << B_YIN);
    localparam logic [23:0] V_T4ADD  = (ONE << B_CSIGN) | (ONE << B_ZLOWIN) | (ONE << B_ADD);
    localparam logic [23:0] V_T4AND  = (ONE << B_CSIGN) | (ONE << B_ZLOWIN) | (ONE << B_AND);
    localparam logic [23:0] V_T4OR   = (ONE << B_CSIGN) | (ONE << B_ZLOWIN) | (ONE << B_OR);
    localparam logic [23:0] V_T5     = (ONE << B_ZLOWOUT) | (ONE << B_GRA) | (ONE << B_RIN) | (ONE << B_DONE);

    localparam logic [31:0] ADDI_IR = 32'h6100_0005;
    localparam logic [31:0] ANDI_IR = 32'h68A0_0000;
    localparam logic [31:0] ORI_IR  = 32'h70A0_0000;

    logic        clock = 1'b0;
    logic        clear;
    logic        run, step_mode, mem_ready;
    logic [31:0] ir;
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;

    always #5 clock = ~clock;

    imm_op_sequencer_if bus8 ();
    imm_op_sequencer_if bus4 ();

    assign bus8.run = run;  assign bus8.step_mode = step_mode;
    assign bus8.mem_ready = mem_ready;  assign bus8.ir = ir;
    assign bus4.run = run;  assign bus4.step_mode = step_mode;
    assign bus4.mem_ready = mem_ready;  assign bus4.ir = ir;

    imm_op_sequencer #(.TIMEOUT(8)) u_dut8 (.clock(clock), .clear(clear), .bus(bus8.master));
    imm_op_sequencer #(.TIMEOUT(4)) u_dut4 (.clock(clock), .clear(clear), .bus(bus4.master));

    logic [23:0] act8, act4;
    assign act8 = {bus8.PCout, bus8.MARin, bus8.IncPC, bus8.Zlowin, bus8.Zlowout, bus8.PCin, bus8.Read, bus8.MD_read,
                   bus8.MDRin, bus8.MDRout, bus8.IRin, bus8.Gra, bus8.Grb, bus8.Rin, bus8.Rout, bus8.BAout, bus8.Yin,
                   bus8.Csignout, bus8.ADD, bus8.AND, bus8.OR, bus8.done, bus8.illegal, bus8.bus_error};
    assign act4 = {bus4.PCout, bus4.MARin, bus4.IncPC, bus4.Zlowin, bus4.Zlowout, bus4.PCin, bus4.Read, bus4.MD_read,
                   bus4.MDRin, bus4.MDRout, bus4.IRin, bus4.Gra, bus4.Grb, bus4.Rin, bus4.Rout, bus4.BAout, bus4.Yin,
                   bus4.Csignout, bus4.ADD, bus4.AND, bus4.OR, bus4.done, bus4.illegal, bus4.bus_error};

    // Model: ph = position in the instruction timeline (0 idle, 1..6 = T0..T5),
    // wt = T1 cycles already spent, mop = ALU function remembered at decode (1 add, 2 and, 3 or).
    int ph  [2] = '{0, 0};
    int wt  [2] = '{0, 0};
    int mop [2] = '{0, 0};

    function automatic int tmo_of(int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int alu_of(logic [4:0] opc);
        case (opc)
            5'b01100: return 1;
            5'b01101: return 2;
            5'b01110: return 3;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [23:0] model_out(int k);
        logic [23:0] v;
        v = '0;
        if (clear) return v;
        case (ph[k])
            1: v = V_T0;
            2: begin
                v[B_READ] = 1'b1; v[B_MDREAD] = 1'b1; v[B_MDRIN] = 1'b1;
                if (wt[k] == 0) begin v[B_ZLOWOUT] = 1'b1; v[B_PCIN] = 1'b1; end
                if (!mem_ready && wt[k] == tmo_of(k) - 1) v[B_BERR] = 1'b1;
            end
            3: v = V_T2;
            4: begin
                if (alu_of(ir[31:27]) != 0) v = (ir[22:19] == 4'd0) ? V_T3B : V_T3R;
                else v[B_ILL] = 1'b1;
            end
            5: begin
                v[B_CSIGN] = 1'b1; v[B_ZLOWIN] = 1'b1;
                v[B_ADD] = (mop[k] == 1); v[B_AND] = (mop[k] == 2); v[B_OR] = (mop[k] == 3);
            end
            6: v = V_T5;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] <= 0; wt[k] <= 0; mop[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (ph[k])
                    0: if (run) ph[k] <= 1;
                    1: begin ph[k] <= 2; wt[k] <= 0; end
                    2: begin
                        if (mem_ready) ph[k] <= 3;
                        else if (wt[k] == tmo_of(k) - 1) ph[k] <= 0;
                        else wt[k] <= wt[k] + 1;
                    end
                    3: ph[k] <= 4;
                    4: begin
                        if (alu_of(ir[31:27]) != 0) begin mop[k] <= alu_of(ir[31:27]); ph[k] <= 5; end
                        else ph[k] <= 0;
                    end
                    5: ph[k] <= 6;
                    6: ph[k] <= (run && !step_mode) ? 1 : 0;
                    default: ph[k] <= 0;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        logic [23:0] e8, e4;
        cycle++;
        e8 = model_out(0);
        e4 = model_out(1);
        checks += 2;
        if (act8 !== e8) begin
            errors++;
            $display("FAIL model_t8 cycle %0d: got %h expected %h", cycle, act8, e8);
        end
        if (act4 !== e4) begin
            errors++;
            $display("FAIL model_t4 cycle %0d: got %h expected %h", cycle, act4, e4);
        end
    end

    task automatic lit(string name, logic [23:0] got, logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
        else $display("ok   %s = %h", name, got);
    endtask

    task automatic chk_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
        else $display("ok   %s = %0d", name, got);
    endtask

    task automatic nc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [23:0] tab [14];
        int pcin8, pcin4, done8, done4, berr8, berr4, nberr, nrin;

        clear = 1'b1; run = 1'b0; step_mode = 1'b0; mem_ready = 1'b0; ir = '0;
        nc(); #2;
        lit("reset_t8", act8, '0);
        lit("reset_t4", act4, '0);
        nc(); clear = 1'b0;

        // addi, Rb=0, run pulsed one cycle
        nc(); ir = ADDI_IR; mem_ready = 1'b1; run = 1'b1; #2; lit("addi_idle", act8, '0);
        nc(); run = 1'b0; #2; lit("addi_t0", act8, V_T0);
        nc(); #2; lit("addi_t1", act8, V_T1F);
        nc(); #2; lit("addi_t2", act8, V_T2);
        nc(); #2; lit("addi_t3", act8, V_T3B);
        nc(); #2; lit("addi_t4", act8, V_T4ADD);
        nc(); #2; lit("addi_t5", act8, V_T5);
        nc(); #2; lit("addi_back_idle", act8, '0);

        // andi then ori back to back; ir changes during the first T4 to prove the latch
        tab = '{V_T0, V_T1F, V_T2, V_T3R, V_T4AND, V_T5, V_T0, V_T1F, V_T2, V_T3R, V_T4OR, V_T5, '0, '0};
        nc(); ir = ANDI_IR; run = 1'b1; #2;
        for (int i = 0; i < 12; i++) begin
            nc();
            if (i == 4) ir = ORI_IR;
            if (i == 11) run = 1'b0;
            #2; lit($sformatf("b2b_c%0d", i), act8, tab[i]);
        end
        nc(); #2; lit("b2b_idle", act8, '0);

        // single-step with run held: one IDLE cycle between instructions
        tab = '{V_T0, V_T1F, V_T2, V_T3B, V_T4ADD, V_T5, '0, V_T0, V_T1F, V_T2, V_T3B, V_T4ADD, V_T5, '0};
        nc(); ir = ADDI_IR; step_mode = 1'b1; run = 1'b1; #2;
        for (int i = 0; i < 14; i++) begin
            nc();
            if (i == 12) run = 1'b0;
            #2; lit($sformatf("step_c%0d", i), act8, tab[i]);
        end
        step_mode = 1'b0;

        // three wait cycles; ready arrives on the 4th T1 cycle (the TIMEOUT=4 boundary)
        pcin8 = 0; pcin4 = 0; done8 = -1; done4 = -1; nberr = 0;
        nc(); ir = ADDI_IR; mem_ready = 1'b0; run = 1'b1; #2;
        for (int i = 0; i < 12; i++) begin
            nc();
            if (i == 0) run = 1'b0;
            if (i == 4) mem_ready = 1'b1;
            #2;
            pcin8 += int'(act8[B_PCIN]); pcin4 += int'(act4[B_PCIN]);
            nberr += int'(act8[B_BERR]) + int'(act4[B_BERR]);
            if (act8[B_DONE]) done8 = i;
            if (act4[B_DONE]) done4 = i;
        end
        chk_int("wait3_latency_t8", done8 + 1, 9);
        chk_int("wait3_latency_t4", done4 + 1, 9);
        chk_int("wait3_pcin_t8", pcin8, 1);
        chk_int("wait3_pcin_t4", pcin4, 1);
        chk_int("wait3_bus_error", nberr, 0);

        // memory never ready: bus_error on the TIMEOUT-th T1 cycle
        berr8 = -1; berr4 = -1; nberr = 0; nrin = 0;
        nc(); mem_ready = 1'b0; run = 1'b1; #2;
        for (int i = 0; i < 13; i++) begin
            nc();
            if (i == 0) run = 1'b0;
            #2;
            if (act8[B_BERR]) berr8 = i;
            if (act4[B_BERR]) berr4 = i;
            nberr += int'(act8[B_BERR]) + int'(act4[B_BERR]);
            nrin  += int'(act8[B_RIN]) + int'(act4[B_RIN]);
            if (i == 5) lit("timeout_t4_idle", act4, '0);
        end
        chk_int("timeout_cycle_t4", berr4, 4);
        chk_int("timeout_cycle_t8", berr8, 8);
        chk_int("timeout_pulses", nberr, 2);
        chk_int("timeout_rin", nrin, 0);

        // illegal opcode
        nc(); ir = 32'hF800_0000; mem_ready = 1'b1; run = 1'b1; #2;
        nc(); run = 1'b0;
        nc(); nc();
        nc(); #2;
        lit("illegal_t3_t8", act8, ONE << B_ILL);
        lit("illegal_t3_t4", act4, ONE << B_ILL);
        nc(); #2; lit("illegal_after", act8, '0);

        // asynchronous clear in the middle of T4
        nc(); ir = ADDI_IR; run = 1'b1; #2;
        nc(); run = 1'b0;
        nc(); nc(); nc();
        nc(); #2; lit("rst_pre_t4", act8, V_T4ADD);
        clear = 1'b1; #1;
        lit("rst_async_t8", act8, '0);
        lit("rst_async_t4", act4, '0);
        nc(); clear = 1'b0; run = 1'b1; #2; lit("rst_idle", act8, '0);
        nc(); run = 1'b0; #2; lit("rst_restart_t0", act8, V_T0);
        repeat (7) nc();

        // randomized traffic, checked by the per-cycle model comparison
        for (int i = 0; i < 800; i++) begin
            nc();
            run       = ($urandom_range(0, 3) != 0);
            step_mode = $urandom_range(0, 1) != 0;
            mem_ready = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0: ir = {5'b01100, 27'($urandom)};
                1: ir = {5'b01101, 27'($urandom)};
                2: ir = {5'b01110, 27'($urandom)};
                default: ir = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) ir[22:19] = 4'd0;
            clear = ($urandom_range(0, 149) == 0);
        end
        nc(); clear = 1'b0; run = 1'b0;
        repeat (3) nc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
